// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver: assembles DATA_W bits LSB-first plus a trailing parity bit,
// flags parity mismatches and keeps a saturating count of failed frames.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    function automatic logic parity_check(input logic acc, input logic par_bit, input logic odd);
        return acc ^ par_bit ^ odd;
    endfunction

    state_t            state_r, state_n;
    logic [DATA_W-1:0] shift_r, shift_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic              acc_r, acc_n;
    logic              done_s;
    logic              check_s;
    logic [7:0]        err_count_n;

    logic [DATA_W-1:0] data_out_r;
    logic              data_valid_r;
    logic              parity_err_r;
    logic              busy_r;
    logic [7:0]        err_count_r;

    // Next-state and datapath next values; frame_start restarts from any state
    always_comb begin
        state_n = state_r;
        shift_n = shift_r;
        cnt_n   = cnt_r;
        acc_n   = acc_r;
        done_s  = 1'b0;
        check_s = parity_check(acc_r, bit_in, PARITY_ODD);
        if (frame_start) begin
            state_n = ST_DATA;
            shift_n = {DATA_W{1'b0}};
            cnt_n   = {CNT_W{1'b0}};
            acc_n   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        shift_n = {bit_in, shift_r[DATA_W-1:1]};
                        acc_n   = acc_r ^ bit_in;
                        cnt_n   = cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_BIT) begin
                            state_n = ST_PARITY;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else begin
                        state_n = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        done_s  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_PARITY;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Error counter: clear beats a same-cycle increment, increment saturates
    always_comb begin
        err_count_n = err_count_r;
        if (err_clr) begin
            err_count_n = 8'd0;
        end else if (done_s && check_s && (err_count_r != 8'hFF)) begin
            err_count_n = err_count_r + 8'd1;
        end else begin
            err_count_n = err_count_r;
        end
    end

    // Frame state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            shift_r <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            shift_r <= shift_n;
            cnt_r   <= cnt_n;
            acc_r   <= acc_n;
        end
    end

    // Output registers; word and flag only change when a frame completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r   <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
            err_count_r  <= 8'd0;
        end else begin
            data_valid_r <= done_s;
            busy_r       <= (state_n != ST_IDLE);
            err_count_r  <= err_count_n;
            if (done_s) begin
                data_out_r   <= shift_r;
                parity_err_r <= check_s;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign parity_err = parity_err_r;
    assign busy       = busy_r;
    assign err_count  = err_count_r;

endmodule
